// File: rtl/abro_n.sv
// abro_n: N-event ABRO controller with optional strict ordering,
// automatic re-arm and a wrapping completion counter.
module abro_n #(
  parameter int N          = 2,
  parameter int ORDERED    = 0,
  parameter int AUTO_REARM = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     ev,
  input  logic             restart,
  output logic             O,
  output logic [N-1:0]     seen,
  output logic [1:0]       state,
  output logic             order_err,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [1:0] WAIT = 2'd0;
  localparam logic [1:0] DONE = 2'd1;

  logic [1:0]       state_q, state_n;
  logic [N-1:0]     seen_q, seen_n;
  logic             o_q, o_n;
  logic             err_q, err_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic [N-1:0]     acc;
  logic [N-1:0]     seen_w;
  logic             bad;
  logic             run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT;
      seen_q  <= '0;
      o_q     <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      seen_q  <= seen_n;
      o_q     <= o_n;
      err_q   <= err_n;
      cnt_q   <= cnt_n;
    end
  end

  // seen is a contiguous low mask in ordered mode, so its clear bits
  // are exactly the indices at or above the expected one.
  always_comb begin
    acc = '0;
    bad = 1'b0;
    run = 1'b1;
    if (ORDERED != 0) begin
      for (int i = 0; i < N; i++) begin
        if (!seen_q[i]) begin
          if (run && ev[i]) begin
            acc[i] = 1'b1;
          end else begin
            run = 1'b0;
            if (ev[i]) bad = 1'b1;
          end
        end
      end
    end else begin
      acc = ev;
    end
  end

  assign seen_w = seen_q | acc;

  always_comb begin
    state_n = state_q;
    seen_n  = seen_q;
    o_n     = 1'b0;
    err_n   = err_q;
    cnt_n   = cnt_q;
    if (restart) begin
      state_n = WAIT;
      seen_n  = '0;
      err_n   = 1'b0;
    end else begin
      case (state_q)
        WAIT: begin
          seen_n = seen_w;
          err_n  = err_q | bad;
          if (&seen_w) begin
            state_n = DONE;
            o_n     = 1'b1;
            cnt_n   = cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (AUTO_REARM != 0 && ev == '0) begin
            state_n = WAIT;
            seen_n  = '0;
            err_n   = 1'b0;
          end
        end
        default: begin
          state_n = WAIT;
          seen_n  = '0;
          err_n   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    O         = o_q;
    seen      = seen_q;
    state     = state_q;
    order_err = err_q;
    done_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_abro_n.sv
// tb_abro_n: directed checks of abro_n across several
// parameterisations sharing one clock and reset.
module tb_abro_n;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // reference: N=2 unordered
  logic [1:0] r_ev; logic r_rs, r_o, r_err;
  logic [1:0] r_seen, r_st; logic [7:0] r_cnt;
  abro_n u_ref (.clk(clk), .reset(reset), .ev(r_ev),
    .restart(r_rs), .O(r_o), .seen(r_seen), .state(r_st),
    .order_err(r_err), .done_cnt(r_cnt));

  // ordered: N=4
  logic [3:0] d_ev; logic d_rs, d_o, d_err;
  logic [3:0] d_seen; logic [1:0] d_st; logic [7:0] d_cnt;
  abro_n #(.N(4), .ORDERED(1)) u_ord (.clk(clk), .reset(reset),
    .ev(d_ev), .restart(d_rs), .O(d_o), .seen(d_seen),
    .state(d_st), .order_err(d_err), .done_cnt(d_cnt));

  // collisions: N=4 unordered
  logic [3:0] f_ev; logic f_rs, f_o, f_err;
  logic [3:0] f_seen; logic [1:0] f_st; logic [7:0] f_cnt;
  abro_n #(.N(4)) u_four (.clk(clk), .reset(reset),
    .ev(f_ev), .restart(f_rs), .O(f_o), .seen(f_seen),
    .state(f_st), .order_err(f_err), .done_cnt(f_cnt));

  // auto re-arm: N=2
  logic [1:0] a_ev; logic a_rs, a_o, a_err;
  logic [1:0] a_seen, a_st; logic [7:0] a_cnt;
  abro_n #(.AUTO_REARM(1)) u_auto (.clk(clk), .reset(reset),
    .ev(a_ev), .restart(a_rs), .O(a_o), .seen(a_seen),
    .state(a_st), .order_err(a_err), .done_cnt(a_cnt));

  // counter wrap: CNT_W=2
  logic [1:0] w_ev; logic w_rs, w_o, w_err;
  logic [1:0] w_seen, w_st; logic [1:0] w_cnt;
  abro_n #(.CNT_W(2)) u_wrap (.clk(clk), .reset(reset),
    .ev(w_ev), .restart(w_rs), .O(w_o), .seen(w_seen),
    .state(w_st), .order_err(w_err), .done_cnt(w_cnt));

  // single event: N=1
  logic [0:0] s_ev; logic s_rs, s_o, s_err;
  logic [0:0] s_seen; logic [1:0] s_st; logic [7:0] s_cnt;
  abro_n #(.N(1)) u_one (.clk(clk), .reset(reset),
    .ev(s_ev), .restart(s_rs), .O(s_o), .seen(s_seen),
    .state(s_st), .order_err(s_err), .done_cnt(s_cnt));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    r_ev = '0; r_rs = 0; d_ev = '0; d_rs = 0;
    f_ev = '0; f_rs = 0; a_ev = '0; a_rs = 0;
    w_ev = '0; w_rs = 0; s_ev = '0; s_rs = 0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({r_o, r_seen, r_st, r_err, r_cnt} !== 14'h0) begin
      errors++;
      $display("FAIL reset_ref got %h want 0",
        {r_o, r_seen, r_st, r_err, r_cnt});
    end
    checks++;
    if ({d_o, d_seen, d_st, d_err, d_cnt} !== 16'h0) begin
      errors++;
      $display("FAIL reset_ord got %h want 0",
        {d_o, d_seen, d_st, d_err, d_cnt});
    end
  endtask

  task automatic test_reference;
    r_ev = 2'b01; tick();
    checks++;
    if ({r_seen, r_o, r_st} !== {2'b01, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL ref_first got %b%b%b want 01 0 00",
        r_seen, r_o, r_st);
    end
    r_ev = 2'b10; tick();
    checks++;
    if ({r_seen, r_o, r_st, r_cnt} !== {2'b11, 1'b1, 2'd1, 8'd1})
    begin
      errors++;
      $display("FAIL ref_done got seen=%b O=%b st=%0d cnt=%0d want 11 1 1 1",
        r_seen, r_o, r_st, r_cnt);
    end
    r_ev = 2'b11; tick();
    checks++;
    if ({r_o, r_st} !== {1'b0, 2'd1}) begin
      errors++;
      $display("FAIL ref_hold1 got O=%b st=%0d want 0 1", r_o, r_st);
    end
    tick();
    checks++;
    if ({r_o, r_st, r_cnt} !== {1'b0, 2'd1, 8'd1}) begin
      errors++;
      $display("FAIL ref_hold2 got O=%b st=%0d cnt=%0d want 0 1 1",
        r_o, r_st, r_cnt);
    end
    r_rs = 1'b1; tick();
    checks++;
    if ({r_seen, r_o, r_st, r_cnt} !== {2'b00, 1'b0, 2'd0, 8'd1})
    begin
      errors++;
      $display("FAIL ref_restart got seen=%b O=%b st=%0d cnt=%0d want 00 0 0 1",
        r_seen, r_o, r_st, r_cnt);
    end
    r_rs = 1'b0; tick();
    checks++;
    if ({r_seen, r_o, r_cnt} !== {2'b11, 1'b1, 8'd2}) begin
      errors++;
      $display("FAIL ref_both got seen=%b O=%b cnt=%0d want 11 1 2",
        r_seen, r_o, r_cnt);
    end
    tick();
    checks++;
    if (r_o !== 1'b0) begin
      errors++;
      $display("FAIL ref_no_double got O=%b want 0", r_o);
    end
    r_ev = '0;
  endtask

  task automatic test_ordered;
    d_ev = 4'b0001; tick();
    checks++;
    if ({d_seen, d_err} !== {4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL ord_first got seen=%b err=%b want 0001 0",
        d_seen, d_err);
    end
    d_ev = 4'b1010; tick();
    checks++;
    if ({d_seen, d_err, d_o} !== {4'b0011, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ord_gap got seen=%b err=%b O=%b want 0011 1 0",
        d_seen, d_err, d_o);
    end
    d_ev = 4'b1100; tick();
    checks++;
    if ({d_seen, d_err, d_o, d_st, d_cnt} !==
        {4'b1111, 1'b1, 1'b1, 2'd1, 8'd1}) begin
      errors++;
      $display("FAIL ord_done got seen=%b err=%b O=%b st=%0d cnt=%0d",
        d_seen, d_err, d_o, d_st, d_cnt);
    end
    d_ev = '0; d_rs = 1'b1; tick();
    checks++;
    if ({d_seen, d_err, d_o, d_st} !== {4'b0000, 1'b0, 1'b0, 2'd0})
    begin
      errors++;
      $display("FAIL ord_restart got seen=%b err=%b O=%b st=%0d",
        d_seen, d_err, d_o, d_st);
    end
    d_rs = 1'b0;
    // ev[0] low: nothing accepted, higher bit flags error
    d_ev = 4'b0100; tick();
    checks++;
    if ({d_seen, d_err} !== {4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL ord_miss got seen=%b err=%b want 0000 1",
        d_seen, d_err);
    end
    d_ev = '0;
  endtask

  task automatic test_collisions;
    f_ev = 4'b1111; tick();
    checks++;
    if ({f_o, f_cnt} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL col_round got O=%b cnt=%0d want 1 1", f_o, f_cnt);
    end
    f_ev = '0; f_rs = 1'b1; tick();
    f_rs = 1'b0; f_ev = 4'b0111; tick();
    checks++;
    if (f_seen !== 4'b0111) begin
      errors++;
      $display("FAIL col_partial got seen=%b want 0111", f_seen);
    end
    f_ev = 4'b1000; f_rs = 1'b1; tick();
    checks++;
    if ({f_o, f_seen, f_st, f_cnt} !== {1'b0, 4'b0000, 2'd0, 8'd1})
    begin
      errors++;
      $display("FAIL col_restart got O=%b seen=%b st=%0d cnt=%0d want 0 0000 0 1",
        f_o, f_seen, f_st, f_cnt);
    end
    f_rs = 1'b0; f_ev = 4'b0111; tick();
    f_ev = 4'b1000; reset = 1'b1; tick();
    reset = 1'b0; f_ev = '0;
    checks++;
    if ({f_o, f_seen, f_st, f_err, f_cnt} !== 16'h0) begin
      errors++;
      $display("FAIL col_reset got %h want 0",
        {f_o, f_seen, f_st, f_err, f_cnt});
    end
  endtask

  task automatic test_auto_rearm;
    a_ev = 2'b11; tick();
    checks++;
    if ({a_o, a_st, a_cnt} !== {1'b1, 2'd1, 8'd1}) begin
      errors++;
      $display("FAIL auto_first got O=%b st=%0d cnt=%0d want 1 1 1",
        a_o, a_st, a_cnt);
    end
    tick(); tick();
    checks++;
    if ({a_o, a_st} !== {1'b0, 2'd1}) begin
      errors++;
      $display("FAIL auto_hold got O=%b st=%0d want 0 1", a_o, a_st);
    end
    a_ev = 2'b00; tick();
    checks++;
    if ({a_st, a_seen} !== {2'd0, 2'b00}) begin
      errors++;
      $display("FAIL auto_rearm got st=%0d seen=%b want 0 00",
        a_st, a_seen);
    end
    a_ev = 2'b11; tick();
    checks++;
    if ({a_o, a_cnt} !== {1'b1, 8'd2}) begin
      errors++;
      $display("FAIL auto_second got O=%b cnt=%0d want 1 2",
        a_o, a_cnt);
    end
    a_ev = '0;
  endtask

  task automatic test_wrap;
    logic [1:0] exp [5];
    exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int k = 0; k < 5; k++) begin
      w_ev = 2'b11; tick();
      checks++;
      if ({w_o, w_cnt} !== {1'b1, exp[k]}) begin
        errors++;
        $display("FAIL wrap_%0d got O=%b cnt=%0d want 1 %0d",
          k, w_o, w_cnt, exp[k]);
      end
      w_ev = '0; w_rs = 1'b1; tick();
      w_rs = 1'b0;
    end
  endtask

  task automatic test_single_and_illegal;
    s_ev = 1'b1; tick();
    checks++;
    if ({s_o, s_seen, s_st} !== {1'b1, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL one_done got O=%b seen=%b st=%0d want 1 1 1",
        s_o, s_seen, s_st);
    end
    s_ev = 1'b0; s_rs = 1'b1; tick();
    s_rs = 1'b0;
    force u_one.state_q = 2'd3;
    #1;
    release u_one.state_q;
    tick();
    checks++;
    if ({s_st, s_o, s_seen} !== {2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL one_illegal got st=%0d O=%b seen=%b want 0 0 0",
        s_st, s_o, s_seen);
    end
  endtask

  initial begin
    test_reset();
    test_reference();
    test_ordered();
    test_collisions();
    test_auto_rearm();
    test_wrap();
    test_single_and_illegal();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
